// File: rtl/shot_pkg.sv
// Shared definitions for the shot pipeline stages.
// Entity field layout, screen limits and scanner states.
package shot_pkg;

  localparam int unsigned ENT_W      = 34;
  localparam int unsigned COORD_W    = 10;

  localparam int unsigned ACTIVE_BIT = 33;
  localparam int unsigned TYPE_LSB   = 30;
  localparam int unsigned TYPE_W     = 3;
  localparam int unsigned YQ_LSB     = 28;
  localparam int unsigned XQ_LSB     = 26;
  localparam int unsigned Q_W        = 2;
  localparam int unsigned Y_LSB      = 16;
  localparam int unsigned X_LSB      = 6;
  localparam int unsigned DIR_LSB    = 0;
  localparam int unsigned DIR_W      = 6;

  localparam int unsigned SCREEN_W_D = 640;
  localparam int unsigned SCREEN_H_D = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } scan_state_t;

endpackage

// File: rtl/shot_bounds_check.sv
// Combinational active / off-screen classification of one entity.
// Coordinates are unsigned, so a wrap below zero reads as off-screen.
module shot_bounds_check
  import shot_pkg::*;
#(
  parameter int unsigned ENTITY_SIZE = ENT_W,
  parameter int unsigned SCREEN_W    = SCREEN_W_D,
  parameter int unsigned SCREEN_H    = SCREEN_H_D
) (
  input  logic [ENTITY_SIZE-1:0] i_entity,
  output logic                   o_active,
  output logic                   o_offscreen
);

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_unused;

  assign w_x = i_entity[X_LSB +: COORD_W];
  assign w_y = i_entity[Y_LSB +: COORD_W];

  assign o_active    = i_entity[ACTIVE_BIT];
  assign o_offscreen = (32'(w_x) >= SCREEN_W)
                    || (32'(w_y) >= SCREEN_H);

  assign w_unused = ^{i_entity[TYPE_LSB +: TYPE_W],
                      i_entity[YQ_LSB +: Q_W],
                      i_entity[XQ_LSB +: Q_W],
                      i_entity[DIR_LSB +: DIR_W]};

endmodule

// File: rtl/shot_scanner.sv
// Per-frame walk of the shot array: retire off-screen shots,
// stream on-screen ones to the renderer one entity at a time.
module shot_scanner
  import shot_pkg::*;
#(
  parameter int unsigned SHOT_COUNT  = 10,
  parameter int unsigned ENTITY_SIZE = ENT_W,
  parameter int unsigned ADDR_W      = $clog2(SHOT_COUNT),
  parameter int unsigned SCREEN_W    = SCREEN_W_D,
  parameter int unsigned SCREEN_H    = SCREEN_H_D
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic [SHOT_COUNT-1:0][ENTITY_SIZE-1:0] shots_data,
  output logic                   delete_shot,
  output logic [ADDR_W-1:0]      shot_address,
  output logic                   ent_valid,
  input  logic                   ent_ready,
  output logic [ENTITY_SIZE-1:0] ent_data,
  output logic [ADDR_W-1:0]      ent_index,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   overrun
);

  scan_state_t              r_state;
  scan_state_t              w_state_nxt;
  logic [ADDR_W-1:0]        r_idx;
  logic [ADDR_W-1:0]        w_idx_nxt;
  logic                     r_del;
  logic [ADDR_W-1:0]        r_del_addr;
  logic [ENTITY_SIZE-1:0]   r_ent_data;
  logic [ADDR_W-1:0]        r_ent_index;
  logic                     r_overrun;

  logic [ENTITY_SIZE-1:0]   w_slot;
  logic                     w_active;
  logic                     w_off;
  logic                     w_last;
  logic                     w_del;
  logic                     w_latch;
  scan_state_t              w_adv_state;
  logic [ADDR_W-1:0]        w_adv_idx;

  assign w_slot = shots_data[r_idx];

  shot_bounds_check #(
    .ENTITY_SIZE (ENTITY_SIZE),
    .SCREEN_W    (SCREEN_W),
    .SCREEN_H    (SCREEN_H)
  ) u_bounds (
    .i_entity    (w_slot),
    .o_active    (w_active),
    .o_offscreen (w_off)
  );

  assign w_last      = (r_idx == ADDR_W'(SHOT_COUNT - 1));
  assign w_adv_state = w_last ? DONE : SCAN;
  assign w_adv_idx   = w_last ? r_idx : r_idx + ADDR_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_del       = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_state_nxt = SCAN;
          w_idx_nxt   = '0;
        end
      end
      SCAN: begin
        if (!w_active) begin
          w_state_nxt = w_adv_state;
          w_idx_nxt   = w_adv_idx;
        end else if (w_off) begin
          w_del       = 1'b1;
          w_state_nxt = w_adv_state;
          w_idx_nxt   = w_adv_idx;
        end else begin
          w_latch     = 1'b1;
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (ent_ready) begin
          w_state_nxt = w_adv_state;
          w_idx_nxt   = w_adv_idx;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_del       <= 1'b0;
      r_del_addr  <= '0;
      r_ent_data  <= '0;
      r_ent_index <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_del      <= w_del;
      r_del_addr <= w_del ? r_idx : '0;
      if (w_latch) begin
        r_ent_data  <= w_slot;
        r_ent_index <= r_idx;
      end
      if (frame_start && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign delete_shot  = r_del;
  assign shot_address = r_del_addr;
  assign ent_valid    = (r_state == EMIT);
  assign ent_data     = r_ent_data;
  assign ent_index    = r_ent_index;
  assign busy         = (r_state != IDLE);
  assign scan_done    = (r_state == DONE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_shot_scanner.sv
// Directed bench for shot_scanner with a small expectation
// scoreboard for deletes, emissions and scan completion.
module tb_shot_scanner;
  import shot_pkg::*;

  localparam int N  = 10;
  localparam int EW = 34;
  localparam int AW = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  frame_start;
  logic [N-1:0][EW-1:0]  shots_data;
  logic                  delete_shot;
  logic [AW-1:0]         shot_address;
  logic                  ent_valid;
  logic                  ent_ready;
  logic [EW-1:0]         ent_data;
  logic [AW-1:0]         ent_index;
  logic                  busy;
  logic                  scan_done;
  logic                  overrun;

  shot_scanner dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .shots_data   (shots_data),
    .delete_shot  (delete_shot),
    .shot_address (shot_address),
    .ent_valid    (ent_valid),
    .ent_ready    (ent_ready),
    .ent_data     (ent_data),
    .ent_index    (ent_index),
    .busy         (busy),
    .scan_done    (scan_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [AW-1:0] addr;
  } del_t;

  typedef struct {
    logic [AW-1:0] idx;
    logic [EW-1:0] data;
  } emit_t;

  del_t  q_del[$];
  emit_t q_emit[$];
  int    q_done[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic act,
                                       input logic [9:0] x,
                                       input logic [9:0] y);
    mk = {act, 3'd2, 2'b01, 2'b10, y, x, 6'h2a};
  endfunction

  task automatic monitor();
    del_t  d;
    emit_t e;
    int    dc;
    if (delete_shot) begin
      if (q_del.size() == 0) begin
        chk("del_spurious", 64'(delete_shot), 64'd0);
      end else begin
        d = q_del.pop_front();
        chk("del_addr", 64'(shot_address), 64'(d.addr));
        chk("del_cycle", 64'(cyc), 64'(d.cyc));
      end
    end
    if (ent_valid && ent_ready) begin
      if (q_emit.size() == 0) begin
        chk("emit_spurious", 64'(ent_valid), 64'd0);
      end else begin
        e = q_emit.pop_front();
        chk("ent_index", 64'(ent_index), 64'(e.idx));
        chk("ent_data", 64'(ent_data), 64'(e.data));
      end
    end
    if (scan_done) begin
      if (q_done.size() == 0) begin
        chk("done_spurious", 64'(scan_done), 64'd0);
      end else begin
        dc = q_done.pop_front();
        chk("done_cycle", 64'(cyc), 64'(dc));
      end
    end
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cyc = 0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("scan_timeout", 64'(busy), 64'd0);
    tick();
    chk("q_del_left", 64'(q_del.size()), 64'd0);
    chk("q_emit_left", 64'(q_emit.size()), 64'd0);
    chk("q_done_left", 64'(q_done.size()), 64'd0);
  endtask

  initial begin
    logic [EW-1:0] snap;
    int            n;

    reset_n     = 1'b0;
    frame_start = 1'b1;
    ent_ready   = 1'b0;
    shots_data  = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outs", 64'({delete_shot, shot_address,
                           ent_valid, ent_data, ent_index,
                           busy, scan_done, overrun}), 64'd0);
    end
    frame_start = 1'b0;
    reset_n     = 1'b1;
    tick();
    chk("rst_idle_busy", 64'(busy), 64'd0);

    // all slots inactive
    ent_ready = 1'b1;
    q_done.push_back(11);
    start_frame();
    while (cyc <= 12) begin
      chk("idle_busy", 64'(busy), 64'(cyc <= 11));
      chk("idle_valid", 64'(ent_valid), 64'd0);
      chk("idle_del", 64'(delete_shot), 64'd0);
      tick();
    end
    chk("idle_overrun", 64'(overrun), 64'd0);
    wait_idle();

    // slot 3 on-screen, renderer stalls 5 cycles
    ent_ready     = 1'b0;
    snap          = mk(1'b1, 10'd100, 10'd200);
    shots_data[3] = snap;
    q_emit.push_back('{idx: 4'd3, data: snap});
    q_done.push_back(17);
    start_frame();
    n = 0;
    while (!ent_valid && n < 50) begin
      tick();
      n++;
    end
    chk("emit_seen", 64'(ent_valid), 64'd1);
    chk("emit_cycle", 64'(cyc), 64'd5);
    for (int k = 0; k < 5; k++) begin
      shots_data[3] = mk(1'b1, 10'(101 + k), 10'd200);
      chk("hold_valid", 64'(ent_valid), 64'd1);
      chk("hold_index", 64'(ent_index), 64'd3);
      chk("hold_data", 64'(ent_data), 64'(snap));
      tick();
    end
    ent_ready = 1'b1;
    tick();
    chk("emit_drop", 64'(ent_valid), 64'd0);
    chk("emit_busy", 64'(busy), 64'd1);
    wait_idle();
    shots_data = '0;

    // two off-screen retirements
    shots_data[2] = mk(1'b1, 10'd1023, 10'd10);
    shots_data[7] = mk(1'b1, 10'd20, 10'd480);
    q_del.push_back('{cyc: 4, addr: 4'd2});
    q_del.push_back('{cyc: 9, addr: 4'd7});
    q_done.push_back(11);
    start_frame();
    while (busy && cyc < 40) begin
      chk("del_no_emit", 64'(ent_valid), 64'd0);
      tick();
    end
    wait_idle();
    shots_data = '0;

    // frame_start mid-scan sets sticky overrun
    q_done.push_back(11);
    start_frame();
    while (cyc < 4) tick();
    chk("ovr_before", 64'(overrun), 64'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    wait_idle();
    chk("ovr_sticky", 64'(overrun), 64'd1);
    tick();
    chk("ovr_idle_busy", 64'(busy), 64'd0);

    // reset during EMIT of slot 5, then restart
    ent_ready     = 1'b0;
    snap          = mk(1'b1, 10'd639, 10'd479);
    shots_data[5] = snap;
    start_frame();
    n = 0;
    while (!ent_valid && n < 50) begin
      tick();
      n++;
    end
    chk("rm_emit_cycle", 64'(cyc), 64'd7);
    chk("rm_emit_index", 64'(ent_index), 64'd5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rm_valid", 64'(ent_valid), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_overrun", 64'(overrun), 64'd0);
    for (int k = 0; k < 3; k++) tick();
    chk("rm_no_done", 64'(scan_done), 64'd0);

    ent_ready = 1'b1;
    q_emit.push_back('{idx: 4'd5, data: snap});
    q_done.push_back(12);
    start_frame();
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shot_scanner.md
# shot_scanner

Per-frame scanner that sits directly downstream of `shot_controller`. It walks the packed shot array once per `frame_start` and retires shots that have left the visible area by pulsing `delete_shot`/`shot_address` back to the controller. Each remaining active shot is streamed one entity at a time over a valid/ready interface to the renderer.

## Interface
- `SHOT_COUNT`, 10: number of shot slots.
- `ENTITY_SIZE`, 34: bits per entity word.
- `ADDR_W`, `$clog2(SHOT_COUNT)`: slot index width.
- `SCREEN_W`, 640: visible x range is 0..SCREEN_W-1.
- `SCREEN_H`, 480: visible y range is 0..SCREEN_H-1.
- `clk` in 1: single clock; all logic on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `frame_start` in 1: one-cycle request to begin a scan.
- `shots_data` in [SHOT_COUNT-1:0][ENTITY_SIZE-1:0]: live shot array.
- `delete_shot` out 1: one-cycle retire strobe to the controller.
- `shot_address` out ADDR_W: slot to retire; valid only while `delete_shot` is high.
- `ent_valid` out 1: entity word available.
- `ent_ready` in 1: renderer accepts the word.
- `ent_data` out ENTITY_SIZE: snapshot of the emitted slot.
- `ent_index` out ADDR_W: slot number of `ent_data`.
- `busy` out 1: scan in progress.
- `scan_done` out 1: one-cycle pulse at end of scan.
- `overrun` out 1: sticky; set when `frame_start` arrives while busy; cleared only by reset.

## Operation
- Entity fields:
  - [33] active
  - [32:30] type
  - [29:28] y step queue
  - [27:26] x step queue
  - [25:16] y
  - [15:6] x
  - [5:0] direction
- Off-screen test: x ≥ SCREEN_W or y ≥ SCREEN_H, as unsigned 10-bit compares. Wrap below 0 (0 → 1023) therefore counts as off-screen.
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - `frame_start` → SCAN, with idx=0.
  - Every other input is ignored.
- SCAN evaluates slot idx from the live `shots_data`:
  - Inactive: advance.
  - Active and off-screen: in the next cycle, `delete_shot`=1 and `shot_address`=idx for exactly one cycle; then advance with no stall.
  - Active and on-screen: latch the slot into `ent_data` and idx into `ent_index`, then go to EMIT.
  - "Advance" means idx+1, or DONE if idx==SHOT_COUNT-1.
- EMIT:
  - `ent_valid`=1.
  - `ent_data` and `ent_index` are held stable regardless of changes to `shots_data`.
  - On `ent_valid && ent_ready`: advance, and drop `ent_valid` the next cycle.
- DONE: `scan_done`=1 for one cycle, then IDLE.
- `frame_start` while not IDLE: ignored, and `overrun` ← 1.
- A delete and a new upstream shot landing in the same slot in the same cycle is resolved by the controller. The scanner only reports.
- Reset value of all outputs is 0; state IDLE, idx 0.
- Reset asserted mid-scan aborts the scan immediately:
  - No `scan_done`.
  - Any pending delete strobe is dropped.

## Timing
- `frame_start` sampled at edge 0 → `busy`=1 from cycle 1.
- SCAN occupies 1 cycle per inactive slot and 1 cycle per deleted slot.
- An emitted slot costs 1 cycle in SCAN plus ≥1 cycle in EMIT.
- `delete_shot` is registered: it appears 1 cycle after its SCAN cycle, and may overlap the next slot's SCAN or EMIT.
- All slots inactive: SCAN in cycles 1..SHOT_COUNT, `scan_done` in cycle SHOT_COUNT+1, `busy`=0 from SHOT_COUNT+2.
- `busy` is high throughout DONE.
- `ent_valid` must never depend combinationally on `ent_ready`.

## Structure
- Shared package `shot_pkg`:
  - Field offset/width localparams (ACTIVE_BIT, X_LSB, Y_LSB, etc.).
  - SCREEN_W/SCREEN_H defaults.
  - `scan_state_t` enum for the FSM states.
- Sub-module `shot_bounds_check`: combinational, takes one entity and produces `active` and `offscreen`. It is reused by the collision stage.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles → all outputs 0; `frame_start` in the same cycles has no effect.
- All 10 slots inactive, `frame_start` at cycle 0 → `scan_done` at cycle 11, `busy` 1..11, no `ent_valid`, no `delete_shot`.
- Slot 3 active with x=100, y=200, `ent_ready` low for 5 cycles → `ent_valid` held, `ent_data` and `ent_index`=3 stable even while `shots_data[3]` x changes; accept on ready → scan continues, then `scan_done`.
- Slot 2 active with x=1023 and slot 7 active with y=480 → two one-cycle `delete_shot` pulses with `shot_address` 2 then 7; no emission; `scan_done` at cycle 11.
- `frame_start` re-asserted at cycle 4 of a scan → ignored, `overrun`=1 and sticky, scan completes normally.
- `reset_n`=0 during EMIT of slot 5 → next cycle `ent_valid`=0 and `busy`=0; no `scan_done`; a fresh `frame_start` restarts at slot 0.
